// File: rtl/muldiv_unit_if.sv
// Handshake/bus bundle for the iterative multiply/divide unit.
//   start   requester -> unit  request, sampled only while busy=0
//   func3   requester -> unit  operation select (RV32M encoding)
//   DataA   requester -> unit  rs1 operand
//   DataB   requester -> unit  rs2 operand
//   busy    unit -> requester  operation in flight
//   done    unit -> requester  one-cycle pulse, result valid
//   result  unit -> requester  registered result, held until next accepted start
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] DataA;
  logic [XLEN-1:0] DataB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, func3, DataA, DataB,
    input  busy, done, result
  );

  modport slave (
    input  start, func3, DataA, DataB,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Fixed latency: start accepted at edge N -> done high in the cycle after edge N+XLEN+2.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_unit_if slave: start/func3/DataA/DataB in, busy/done/result out
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam int unsigned AccW = 2 * XLEN + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q;
  logic [2:0]        func3_q;
  logic [XLEN-1:0]   a_mag_q;
  logic [XLEN-1:0]   b_mag_q;
  logic              neg_a_q;
  logic              neg_b_q;
  logic              b_zero_q;
  logic [CntW-1:0]   cnt_q;
  logic [AccW-1:0]   acc_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  // Operand decode at the request boundary
  logic              signed_a, signed_b, neg_a, neg_b;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [AccW-1:0]   acc_init;

  always_comb begin
    // Only the unsigned variants clear signedness; MULHSU keeps A signed only
    signed_a = !(bus.func3 inside {3'b011, 3'b101, 3'b111});
    signed_b = bus.func3 inside {3'b000, 3'b001, 3'b100, 3'b110};
    neg_a    = signed_a & bus.DataA[XLEN-1];
    neg_b    = signed_b & bus.DataB[XLEN-1];
    a_mag    = neg_a ? (~bus.DataA + 1'b1) : bus.DataA;
    b_mag    = neg_b ? (~bus.DataB + 1'b1) : bus.DataB;
    // Multiply: multiplier sits in the low half. Divide: dividend sits in the low half.
    acc_init = bus.func3[2] ? {{(XLEN + 1){1'b0}}, a_mag} : {{(XLEN + 1){1'b0}}, b_mag};
  end

  // One radix-2 iteration
  logic [XLEN:0]     mul_sum;
  logic [AccW-1:0]   mul_next;
  logic [XLEN:0]     rem_sh;
  logic [AccW-1:0]   div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_mag_q};
    mul_next = acc_q[0] ? {1'b0, mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[AccW-1:1]};
    // Restoring divide: partial remainder shifted left with next dividend bit
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    if (rem_sh >= {1'b0, b_mag_q}) begin
      div_next = {rem_sh - {1'b0, b_mag_q}, acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_next = {rem_sh, acc_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction and half/quotient/remainder select
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   sel_result;

  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q[2*XLEN-1:0] + 1'b1) : acc_q[2*XLEN-1:0];
    // Divide by zero yields all ones regardless of sign; remainder already equals DataA
    if (b_zero_q) begin
      quot_fix = '1;
    end else begin
      quot_fix = (neg_a_q ^ neg_b_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    end
    rem_fix  = neg_a_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    unique case (func3_q)
      3'b000:                 sel_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: sel_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         sel_result = quot_fix;
      default:                sel_result = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      func3_q  <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // busy_q is still high in the cycle done is shown, which blocks a start there
          if (bus.start && !busy_q) begin
            func3_q  <= bus.func3;
            a_mag_q  <= a_mag;
            b_mag_q  <= b_mag;
            neg_a_q  <= neg_a;
            neg_b_q  <= neg_b;
            b_zero_q <= (bus.DataB == '0);
            cnt_q    <= '0;
            acc_q    <= acc_init;
            busy_q   <= 1'b1;
            state_q  <= StCalc;
          end else begin
            busy_q <= 1'b0;
          end
        end
        StCalc: begin
          acc_q <= func3_q[2] ? div_next : mul_next;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(XLEN - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          result_q <= sel_result;
          state_q  <= StDone;
        end
        StDone: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it for 40 edges. inject>0 pulses a conflicting
  // start (different operands/op) just before edge 'inject'.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int inject);
    int first    = 0;
    int pulses   = 0;
    int busy_err = 0;
    @(negedge clk);
    bus.func3 = f;
    bus.DataA = a;
    bus.DataB = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    // Operands may change freely once accepted
    bus.DataA = $urandom;
    bus.DataB = $urandom;
    bus.func3 = f ^ 3'b001;
    for (int k = 1; k <= 40; k++) begin
      if (k == inject) begin
        bus.start = 1'b1;
        bus.DataA = 32'd1000;
        bus.DataB = 32'd3;
        bus.func3 = 3'b101;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (k <= 34 && !bus.busy) busy_err++;
      if (k >= 35 && bus.busy) busy_err++;
    end
    chk({tag, ".latency"}, 32'(first), 32'd34);
    chk({tag, ".pulses"}, 32'(pulses), 32'd1);
    chk({tag, ".busy"}, 32'(busy_err), 32'd0);
    chk({tag, ".result"}, bus.result, exp);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.func3 = 3'b000;
    bus.DataA = '0;
    bus.DataB = '0;
    #12;
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 0);
    run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 0);
    run_op("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5, 0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    // -100 / 7 = -14, conflicting start mid-operation
    run_op("div_inject", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 10);

    // Reset mid-MUL aborts immediately
    @(negedge clk);
    bus.func3 = 3'b000;
    bus.DataA = 32'h1234_5678;
    bus.DataB = 32'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("abort.busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.done", 32'(bus.done), 32'd0);
    chk("abort.result", bus.result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort.held_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul_after_reset", 3'b000, 32'd3, 32'd4, 32'd12, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
